// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared payload type and output-buffer depth for the fifo family.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  typedef logic [7:0] DATA_T;

  localparam int DEPTH = 3;

  // Buffer pointers step 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
    return (ptr == 2'(DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_buf.sv
// ============================================================================
// Module   : stream_buf
// Purpose  : 3-entry circular register buffer with write-enable and dequeue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_buf
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       wr_en,
  input  DATA_T      wr_data,
  input  logic       deq,
  output logic [1:0] count,
  output DATA_T      rd_data
);

  DATA_T      r_mem [DEPTH];
  logic [1:0] r_head;
  logic [1:0] r_tail;
  logic [1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
      r_count <= 2'd0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clear) begin
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
      r_count <= 2'd0;
    end else begin
      if (wr_en) begin
        r_mem[r_tail] <= wr_data;
        r_tail        <= next_ptr(r_tail);
      end
      if (deq) r_head <= next_ptr(r_head);
      r_count <= r_count + {1'b0, wr_en} - {1'b0, deq};
    end
  end

  assign count   = r_count;
  // Zero the payload when empty so stale entries never leak to the consumer.
  assign rd_data = (r_count != 2'd0) ? r_mem[r_head] : '0;

endmodule

`default_nettype wire

// File: rtl/fifo_stream_out.sv
// ============================================================================
// Module   : fifo_stream_out
// Purpose  : Fifo read-side adapter: credit-based pops into a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_out
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  output logic       r_req,
  input  logic       r_stall,
  input  DATA_T      r_data,
  output logic       m_valid,
  input  logic       m_ready,
  output DATA_T      m_data,
  output logic [1:0] occupancy
);

  logic       r_inflight;
  logic       w_deq;
  logic       w_capture;
  logic [2:0] w_credit;

  // A slot is reserved for every pop in flight so the returning beat always fits.
  assign w_credit  = {1'b0, occupancy} + {2'b00, r_inflight};
  assign r_req     = reset_n && !flush && (w_credit < 3'(DEPTH));
  assign w_capture = r_inflight && !flush;
  assign m_valid   = (occupancy != 2'd0);
  assign w_deq     = m_valid && m_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_inflight <= 1'b0;
    else          r_inflight <= r_req && !r_stall;
  end

  stream_buf u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .wr_en   (w_capture),
    .wr_data (r_data),
    .deq     (w_deq),
    .count   (occupancy),
    .rd_data (m_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_out.sv
// ============================================================================
// Module   : tb_fifo_stream_out
// Purpose  : Directed vectors and sequences for fifo_stream_out with a fifo model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_out;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic       r_req;
  logic       r_stall = 1'b1;
  DATA_T      r_data = '0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  DATA_T      m_data;
  logic [1:0] occupancy;

  int    checks = 0;
  int    failures = 0;
  logic  force_stall = 1'b0;
  logic  acc;
  DATA_T fifo_q[$];
  DATA_T exp_q[$];

  fifo_stream_out dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .r_req     (r_req),
    .r_stall   (r_stall),
    .r_data    (r_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Fifo model: one-cycle read latency, stall when empty or forced.
  always @(posedge clk) begin
    acc = r_req && !r_stall;
    #1;
    if (acc && fifo_q.size() > 0) r_data = fifo_q.pop_front();
    r_stall = force_stall || (fifo_q.size() == 0);
  end

  task automatic upd_stall();
    r_stall = force_stall || (fifo_q.size() == 0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       m_ready;
    logic       flush;
    logic       exp_req;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_occ;
  } vec_t;

  vec_t vecs[5];
  int   got;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  2'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd14, 2'd1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd18, 2'd1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd16, 2'd1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  2'd0};

    // Test 1: reset state, then preloaded 14,18,16 streamed at full rate.
    fifo_q = '{8'd14, 8'd18, 8'd16};
    @(negedge clk);
    upd_stall();
    chk("rst_req", int'(r_req), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_occ", int'(occupancy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_ready = 1'b1;
    #1 chk("t1_req_pre", int'(r_req), 1);
    for (int i = 0; i < 5; i++) begin
      m_ready = vecs[i].m_ready;
      flush   = vecs[i].flush;
      step();
      chk($sformatf("t1_req[%0d]", i), int'(r_req), int'(vecs[i].exp_req));
      chk($sformatf("t1_valid[%0d]", i), int'(m_valid), int'(vecs[i].exp_valid));
      chk($sformatf("t1_data[%0d]", i), int'(m_data), int'(vecs[i].exp_data));
      chk($sformatf("t1_occ[%0d]", i), int'(occupancy), int'(vecs[i].exp_occ));
    end
    chk("t1_stall", int'(r_stall), 1);

    // Test 2: backpressure fills the buffer, then release drains in order.
    m_ready = 1'b0;
    for (int v = 20; v <= 27; v++) fifo_q.push_back(DATA_T'(v));
    upd_stall();
    repeat (6) step();
    chk("t2_pops", fifo_q.size(), 5);
    chk("t2_occ", int'(occupancy), 3);
    chk("t2_req", int'(r_req), 0);
    chk("t2_data_hold", int'(m_data), 20);
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_valid[%0d]", k), int'(m_valid), 1);
      chk($sformatf("t2_data[%0d]", k), int'(m_data), 20 + k);
      step();
    end
    chk("t2_empty", int'(m_valid), 0);

    // Test 3: long stall, then a single entry 9 appears two edges later.
    force_stall = 1'b1;
    fifo_q.push_back(8'd9);
    upd_stall();
    for (int k = 0; k < 10; k++) begin
      step();
      if (m_valid !== 1'b0 || m_data !== 8'd0)
        chk($sformatf("t3_idle[%0d]", k), int'({m_valid, m_data}), 0);
    end
    chk("t3_idle_valid", int'(m_valid), 0);
    chk("t3_idle_data", int'(m_data), 0);
    force_stall = 1'b0;
    upd_stall();
    step();
    chk("t3_valid_e1", int'(m_valid), 0);
    step();
    chk("t3_valid_e2", int'(m_valid), 1);
    chk("t3_data_e2", int'(m_data), 9);
    step();

    // Test 4: flush with two buffered entries and a pop of 23 in flight.
    m_ready = 1'b0;
    fifo_q.push_back(8'd21);
    fifo_q.push_back(8'd22);
    fifo_q.push_back(8'd23);
    fifo_q.push_back(8'd24);
    upd_stall();
    repeat (3) step();
    chk("t4_occ_pre", int'(occupancy), 2);
    chk("t4_req_pre", int'(r_req), 0);
    chk("t4_data_pre", int'(m_data), 21);
    flush = 1'b1;
    #1 chk("t4_req_flush", int'(r_req), 0);
    step();
    flush = 1'b0;
    chk("t4_occ_post", int'(occupancy), 0);
    chk("t4_valid_post", int'(m_valid), 0);
    m_ready = 1'b1;
    step();
    chk("t4_no23", int'(m_valid), 0);
    step();
    chk("t4_next_valid", int'(m_valid), 1);
    chk("t4_next_data", int'(m_data), 24);
    step();

    // Test 5: asynchronous reset between edges mid-stream.
    m_ready = 1'b0;
    for (int v = 30; v <= 35; v++) fifo_q.push_back(DATA_T'(v));
    upd_stall();
    repeat (4) step();
    chk("t5_occ_pre", int'(occupancy), 3);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_req_rst", int'(r_req), 0);
    chk("t5_valid_rst", int'(m_valid), 0);
    chk("t5_data_rst", int'(m_data), 0);
    chk("t5_occ_rst", int'(occupancy), 0);
    step();
    reset_n = 1'b1;
    m_ready = 1'b1;
    step();
    chk("t5_valid_e1", int'(m_valid), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t5_valid[%0d]", k), int'(m_valid), 1);
      chk($sformatf("t5_data[%0d]", k), int'(m_data), 33 + k);
    end
    step();
    chk("t5_drained", int'(m_valid), 0);

    // Test 6: 200 random entries, alternating consumer, random stalls.
    for (int k = 0; k < 200; k++) begin
      DATA_T v;
      v = DATA_T'($urandom_range(0, 255));
      fifo_q.push_back(v);
      exp_q.push_back(v);
    end
    got = 0;
    for (int cyc = 0; cyc < 3000 && got < 200; cyc++) begin
      m_ready     = (cyc % 2) == 0;
      force_stall = ($urandom_range(0, 2) == 0);
      upd_stall();
      if (m_valid !== (occupancy != 2'd0))
        chk("t6_valid_occ", int'(m_valid), int'(occupancy != 2'd0));
      if (m_valid && m_ready) begin
        if (m_data !== exp_q[0]) chk("t6_data", int'(m_data), int'(exp_q[0]));
        void'(exp_q.pop_front());
        got++;
      end
      step();
    end
    chk("t6_received", got, 200);
    force_stall = 1'b0;
    upd_stall();
    repeat (3) step();
    chk("t6_no_extra", int'(m_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_stream_out.md
Name: fifo_stream_out

Overview:
Read-side adapter placed directly downstream of the fifo block. It drives the fifo's r_req/r_stall pop interface, absorbs the fifo's one-cycle read latency in a 3-entry output buffer, and presents a valid/ready stream to the consumer. There are no combinational paths from m_ready to r_req, or from r_stall to any output. Full throughput is sustained when the consumer is always ready.

Parameters:
DATA_T, logic [7:0], payload type; must match the fifo's DATA_T.
DEPTH, 3, output buffer entries; localparam, fixed at 3 (the minimum for full rate with 1-cycle read latency).

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous clear of buffer and in-flight pop.
r_req  output  1  pop request to the fifo.
r_stall  input  1  fifo cannot pop (empty).
r_data  input  $bits(DATA_T)  fifo read data, valid the cycle after an accepted pop.
m_valid  output  1  output stream valid.
m_ready  input  1  consumer accepts.
m_data  output  $bits(DATA_T)  output stream payload.
occupancy  output  2  buffered entries, 0..3.

Behaviour:
- Reset is asynchronous on reset_n low. r_req=0, m_valid=0, m_data=0, occupancy=0; head, tail and the inflight flag are cleared. A pop in flight at reset is lost.
- Fifo contract:
  - A pop is accepted at a posedge where r_req && !r_stall.
  - The popped entry is on r_data throughout the following cycle.
  - r_stall=1 with r_req=1 means no pop; r_req simply stays asserted.
- Internal state:
  - inflight <= (r_req && !r_stall) at each edge.
  - count = occupancy.
  - Circular buffer with 2-bit head and tail pointers that wrap 2->0.
- r_req = !flush && (count + inflight) < 3. This is registered state only and never depends on m_ready.
- Capture: when inflight=1 and flush=0, r_data is written at tail on the edge and tail advances.
- Output:
  - m_valid = (count != 0).
  - m_data = buf[head], driven from storage; 0 when empty.
- Dequeue: when m_valid && m_ready, head advances.
- Next count = count + (inflight && !flush) - deq. Simultaneous capture and dequeue leaves count unchanged. Invariant: count + inflight <= 3.
- Latency: r_req accepted at edge N -> captured at edge N+1 -> m_valid during the cycle after N+1. Minimum is 2 edges from pop to output.
- Steady state with m_ready=1 and r_stall=0: count=1, inflight=1, one pop and one output per cycle.
- Stability: while m_valid && !m_ready, m_data and m_valid hold.
- Full: at count=3, or count=2 with inflight=1, r_req=0 until a dequeue frees a slot.
- Empty: at count=0, m_valid=0 and m_data=0.
- Flush, at an edge with flush=1:
  - count, head and tail go to 0 and inflight is cleared.
  - Data returning in that cycle is discarded.
  - r_req=0 during flush.
  - Items already popped from the fifo are dropped by design.
  - A dequeue in the flush cycle is still treated as delivered.
- No error outputs. Behaviour with r_stall toggling mid-request is defined entirely by the acceptance rule above.

Decomposition:
- Shared package fifo_pkg holds the DATA_T typedef and the DEPTH=3 localparam; the fifo and its testbench use the same typedef.
- One natural sub-module, stream_buf: 3-entry register array with head/tail pointers, write-enable and dequeue. fifo_stream_out keeps the credit/inflight logic and the flush handling.

Test Plan:
1. Fifo preloaded 14,18,16, m_ready=1.
   -> r_req high from cycle 0, pops at edges 0,1,2.
   -> m_valid in the cycles after edges 1,2,3 with m_data 14,18,16.
   -> r_stall then rises, r_req stays 1 and m_valid falls after 16.
2. Fifo holds 20..27, m_ready=0.
   -> Exactly 3 pops, occupancy=3, r_req=0, m_data=20 held stable.
   -> m_ready=1 releases 20..27 in order, one per cycle, no gaps after the first.
3. r_stall=1 for 10 cycles.
   -> No pops, m_valid=0, m_data=0.
   -> A single entry 9 becomes poppable: m_valid with m_data=9 two edges after r_stall falls.
4. occupancy=2 (data 21,22) with a pop of 23 in flight, pulse flush.
   -> occupancy=0 and m_valid=0 next cycle, 23 never appears.
   -> Next output is 24.
5. reset_n pulsed low between edges mid-stream.
   -> r_req, m_valid, m_data and occupancy go to 0 immediately, without waiting for an edge.
   -> After release, fetching restarts from the current fifo head.
6. Consumer m_ready pattern 1,0,1,0 over 200 random fifo entries with random r_stall.
   -> Output sequence equals input sequence, no loss or duplication.
   -> occupancy never exceeds 3.
